// File: rtl/poly1305_blkfmt.sv
// Poly1305 stream framer: takes a 32-byte key then message bytes, emits r/s and
// padded 16-byte blocks to a poly1305 core with a load/ready handshake.
module poly1305_blkfmt (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   din,
  input  logic         din_valid,
  input  logic         din_last,
  output logic         din_ready,
  output logic [127:0] r,
  output logic [127:0] s,
  output logic [127:0] m,
  output logic         fb,
  output logic         first,
  output logic         ld,
  input  logic         rdy,
  output logic         last_blk,
  output logic         tag_valid,
  output logic         empty
);

  typedef enum logic [1:0] {KEY, MSG, ISSUE, WAIT} state_e;

  state_e            state_q, state_d;
  logic [4:0]        key_cnt_q, key_cnt_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0][7:0]  r_q, r_d, s_q, s_d, m_q, m_d;
  logic              fb_q, fb_d, first_q, first_d, last_q, last_d;
  logic              tag_q, tag_d, empty_q, empty_d, skip_q, skip_d;
  logic              acc;
  logic [4:0]        pad_idx;

  assign din_ready = reset && (state_q == KEY || state_q == MSG);
  assign acc       = din_valid && din_ready;
  assign ld        = (state_q == ISSUE);
  assign pad_idx   = {1'b0, cnt_q} + 5'd1;

  assign r         = r_q;
  assign s         = s_q;
  assign m         = m_q;
  assign fb        = fb_q;
  assign first     = first_q;
  assign last_blk  = last_q;
  assign tag_valid = tag_q;
  assign empty     = empty_q;

  always_comb begin
    state_d   = state_q;
    key_cnt_d = key_cnt_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    s_d       = s_q;
    m_d       = m_q;
    fb_d      = fb_q;
    first_d   = first_q;
    last_d    = last_q;
    tag_d     = 1'b0;
    empty_d   = 1'b0;
    skip_d    = skip_q;
    case (state_q)
      KEY: begin
        if (acc) begin
          if (!key_cnt_q[4]) r_d[key_cnt_q[3:0]] = din;
          else               s_d[key_cnt_q[3:0]] = din;
          if (din_last) begin
            // Stream ended before any message byte: zero-length message.
            empty_d   = 1'b1;
            key_cnt_d = 5'd0;
            cnt_d     = 4'd0;
          end else begin
            key_cnt_d = key_cnt_q + 5'd1;
            if (key_cnt_q == 5'd31) begin
              state_d = MSG;
              first_d = 1'b1;
              cnt_d   = 4'd0;
              m_d     = '0;
              fb_d    = 1'b0;
              last_d  = 1'b0;
            end
          end
        end
      end
      MSG: begin
        if (acc) begin
          // Short final block gets 0x01 right after the data, zeros above.
          for (int i = 0; i < 16; i++) begin
            if (4'(i) == cnt_q)
              m_d[i] = din;
            else if (din_last && 5'(i) > {1'b0, cnt_q})
              m_d[i] = (5'(i) == pad_idx) ? 8'h01 : 8'h00;
          end
          cnt_d = cnt_q + 4'd1;
          if (din_last || cnt_q == 4'd15) begin
            state_d = ISSUE;
            fb_d    = (cnt_q == 4'd15);
            last_d  = din_last;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        skip_d  = 1'b1;
      end
      WAIT: begin
        // rdy may still reflect the previous block during the cycle after ld.
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (rdy) begin
          tag_d   = last_q;
          state_d = last_q ? KEY : MSG;
          first_d = 1'b0;
          cnt_d   = 4'd0;
          m_d     = '0;
          fb_d    = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: state_d = KEY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= KEY;
      key_cnt_q <= '0;
      cnt_q     <= '0;
      r_q       <= '0;
      s_q       <= '0;
      m_q       <= '0;
      fb_q      <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      tag_q     <= 1'b0;
      empty_q   <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_cnt_q <= key_cnt_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      s_q       <= s_d;
      m_q       <= m_d;
      fb_q      <= fb_d;
      first_q   <= first_d;
      last_q    <= last_d;
      tag_q     <= tag_d;
      empty_q   <= empty_d;
      skip_q    <= skip_d;
    end
  end

endmodule

// File: tb/tb_poly1305_blkfmt.sv
// Directed bench for poly1305_blkfmt: RFC 8439 vector, boundary message lengths,
// key-phase abort, long core stall and reset during WAIT.
module tb_poly1305_blkfmt;

  logic         clk, reset;
  logic [7:0]   din;
  logic         din_valid, din_last, din_ready;
  logic [127:0] r, s, m;
  logic         fb, first, ld, rdy, last_blk, tag_valid, empty;

  poly1305_blkfmt dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_last(din_last), .din_ready(din_ready), .r(r), .s(s), .m(m),
    .fb(fb), .first(first), .ld(ld), .rdy(rdy), .last_blk(last_blk),
    .tag_valid(tag_valid), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0, ntot = 0, tmo = 0;
  int n_ld = 0, n_tag = 0, n_empty = 0, n_dbl = 0;
  int rdy_delay = 2;
  bit prev_ld = 0;
  logic [127:0] ld_m [64];
  logic         ld_fb [64], ld_first [64], ld_last [64];

  logic [7:0] rfc_key [32] = '{
    8'h85, 8'hd6, 8'hbe, 8'h78, 8'h57, 8'h55, 8'h6d, 8'h33,
    8'h7f, 8'h44, 8'h52, 8'hfe, 8'h42, 8'hd5, 8'h06, 8'ha8,
    8'h01, 8'h03, 8'h80, 8'h8a, 8'hfb, 8'h0d, 8'hb2, 8'hfd,
    8'h4a, 8'hbf, 8'hf6, 8'haf, 8'h41, 8'h49, 8'hf5, 8'h1b};
  string rfc_msg = "Cryptographic Forum Research Group";

  // Record every load and pulse seen on the core side.
  initial forever begin
    @(negedge clk);
    if (ld) begin
      if (n_ld < 64) begin
        ld_m[n_ld] = m; ld_fb[n_ld] = fb; ld_first[n_ld] = first; ld_last[n_ld] = last_blk;
      end
      n_ld++;
    end
    if (ld && prev_ld) n_dbl++;
    prev_ld = ld;
    if (tag_valid) n_tag++;
    if (empty) n_empty++;
  end

  // Core model: busy for rdy_delay cycles after each load.
  initial begin
    rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (ld) begin
        #1 rdy = 1'b0;
        repeat (rdy_delay) @(negedge clk);
        #1 rdy = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int t = 0;
    din = b; din_valid = 1'b1; din_last = l;
    while (!din_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) tmo++;
    @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] base);
    for (int i = 0; i < 32; i++) send(base == 8'h00 ? rfc_key[i] : base + 8'(i), 1'b0);
  endtask

  task automatic wait_ld(input int target);
    int t = 0;
    while (n_ld < target && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) tmo++;
  endtask

  task automatic wait_tag(input int t0);
    int t = 0;
    while (n_tag == t0 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) tmo++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int b0, t0, e0, bad, t;
    logic [127:0] cap;
    reset = 1'b0; din = '0; din_valid = 1'b0; din_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {121'd0, din_ready, ld, fb, first, last_blk, tag_valid, empty}, '0);
    chk("rst_rsm", r | s | m, '0);
    reset = 1'b1;
    #1 chk("rst_rel_rdy", din_ready, 1);
    @(negedge clk);

    // RFC 8439 vector, 34-byte message -> 3 blocks
    b0 = n_ld; t0 = n_tag;
    send_key(8'h00);
    for (int i = 0; i < 34; i++) send(rfc_msg[i], i == 33);
    wait_tag(t0);
    chk("rfc_r", r, 128'ha806d542fe52447f336d555778bed685);
    chk("rfc_s", s, 128'h1bf54941aff6bf4afdb20dfb8a800301);
    chk("rfc_nld", n_ld - b0, 3);
    chk("rfc_ld1", {ld_first[b0], ld_fb[b0], ld_last[b0], ld_m[b0][7:0]}, {3'b110, 8'h43});
    chk("rfc_ld2", {ld_first[b0+1], ld_fb[b0+1], ld_last[b0+1]}, 3'b010);
    chk("rfc_ld3_m", ld_m[b0+2], 128'h017075);
    chk("rfc_ld3", {ld_fb[b0+2], ld_last[b0+2]}, 2'b01);
    chk("rfc_tag", n_tag - t0, 1);

    // 32-byte message -> two full blocks, no padding block
    b0 = n_ld; t0 = n_tag;
    send_key(8'h00);
    for (int i = 0; i < 32; i++) send(8'(i), i == 31);
    wait_tag(t0);
    chk("m32_nld", n_ld - b0, 2);
    chk("m32_ld1", {ld_first[b0], ld_fb[b0], ld_last[b0]}, 3'b110);
    chk("m32_ld2", {ld_first[b0+1], ld_fb[b0+1], ld_last[b0+1]}, 3'b011);
    chk("m32_m2", ld_m[b0+1], 128'h1f1e1d1c1b1a19181716151413121110);

    // 1-byte message
    b0 = n_ld; t0 = n_tag;
    send_key(8'h00);
    send(8'haa, 1'b1);
    wait_tag(t0);
    chk("m1_nld", n_ld - b0, 1);
    chk("m1_m", ld_m[b0], 128'h01aa);
    chk("m1_flags", {ld_first[b0], ld_fb[b0], ld_last[b0]}, 3'b101);

    // din_last on key byte 10, then a fresh key
    b0 = n_ld; e0 = n_empty; t0 = n_tag;
    for (int i = 0; i < 11; i++) send(8'hee, i == 10);
    repeat (3) @(negedge clk);
    chk("emp_pulse", n_empty - e0, 1);
    chk("emp_nold", n_ld - b0, 0);
    send_key(8'h40);
    send(8'h55, 1'b1);
    wait_tag(t0);
    chk("emp_r", r, 128'h4f4e4d4c4b4a49484746454443424140);
    chk("emp_s", s, 128'h5f5e5d5c5b5a59585756555453525150);
    chk("emp_m", ld_m[b0], 128'h0155);
    chk("emp_first", ld_first[b0], 1);

    // Core stalls 20 cycles after the first load
    rdy_delay = 20;
    b0 = n_ld; t0 = n_tag;
    send_key(8'h00);
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), 1'b0);
    wait_ld(b0 + 1);
    cap = m;
    chk("stall_cap", cap, 128'h3f3e3d3c3b3a39383736353433323130);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (din_ready !== 1'b0 || m !== cap) bad++;
    end
    chk("stall_hold", bad, 0);
    t = 0;
    while (!rdy && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) tmo++;
    chk("stall_resume", din_ready, 1);
    send(8'h77, 1'b1);
    wait_tag(t0);
    chk("stall_m2", ld_m[b0+1], 128'h0177);
    chk("stall_fl2", {ld_first[b0+1], ld_fb[b0+1], ld_last[b0+1]}, 3'b001);
    rdy_delay = 2;
    repeat (25) @(negedge clk);

    // Reset while waiting on block 2
    rdy_delay = 10;
    b0 = n_ld; t0 = n_tag;
    send_key(8'h00);
    for (int i = 0; i < 20; i++) send(8'(i), i == 19);
    wait_ld(b0 + 2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstw_ctl", {121'd0, din_ready, ld, fb, first, last_blk, tag_valid, empty}, '0);
    chk("rstw_rsm", r | s | m, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    rdy_delay = 2;
    b0 = n_ld;
    send_key(8'h00);
    send(8'h5a, 1'b1);
    wait_tag(t0);
    chk("rstw_nld", n_ld - b0, 1);
    chk("rstw_m", ld_m[b0], 128'h015a);
    chk("rstw_first", {ld_first[b0], ld_last[b0]}, 2'b11);
    chk("rstw_tag", n_tag - t0, 1);

    chk("no_dbl_ld", n_dbl, 0);
    chk("timeouts", tmo, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
